acia_fifo: RTL
==============

Name: acia_fifo

Overview:
- Next-generation 6551-compatible ACIA for the 65C02 bus: same four-register map (RS), CS active-low, RWN.
- Adds parametrised TX and RX FIFOs, an internal programmable baud generator running from the single system clock, and a FIFO-level interrupt.
- Sits between the CPU bus decode and the board UART pins; replaces the unbuffered ACIA where a faster host link needs buffering.

Parameters:
- DEPTH, 16, entries per FIFO (TX and RX); power of two, 4..256.
- CLK_DIV, 13, system clocks per 16x-oversample tick at control divisor 0.
- RX_THRESH, 8, RX FIFO level (1..DEPTH) at or above which the RX level interrupt may fire.

Ports:
- PHI2, input, 1, system clock; all logic on its rising edge.
- RESET, input, 1, synchronous active-high reset.
- CS, input, 1, chip select, active-low.
- RWN, input, 1, 1 = read, 0 = write.
- RS, input, 2, register select.
- DATAIN, input, 8, write data.
- DATAOUT, output, 8, registered read data.
- RXD, input, 1, serial in; asynchronous, double-flopped internally.
- TXD, output, 1, serial out; idle high.
- RTSB, output, 1, request-to-send, active-low.
- CTSB, input, 1, clear-to-send, active-low; double-flopped.
- DTRB, output, 1, equal to NOT command[0].
- IRQn, output, 1, interrupt, active-low, registered.

Behaviour:
- Reset: both FIFOs empty; command, control and error flags 0; TXD = 1; RTSB = 1; DTRB = 1; IRQn = 1; DATAOUT = 0; serialisers idle; baud counter 0.
- Bus access:
  - One access per CS low period, taken on the first cycle CS is sampled low (CS high-to-low, using a registered copy of CS).
  - Holding CS low longer does nothing more.
  - Read data is registered into DATAOUT at that edge and held until the next read.
- RS=00 write: push DATAIN to the TX FIFO. If the TX FIFO is full, drop the byte; contents unchanged.
- RS=00 read: DATAOUT = RX FIFO head, then pop. If the RX FIFO is empty, return the last popped byte with no pop. A read also clears overrun, frame and parity.
- RS=01 read: status.
  - bit7 = IRQ active.
  - bit6 = TX full.
  - bit5 = RX level >= RX_THRESH.
  - bit4 = TX empty.
  - bit3 = RX not empty.
  - bit2 = overrun.
  - bit1 = frame error.
  - bit0 = parity error.
- RS=01 write: programmed reset. Flush both FIFOs, clear errors and command[4:0]. Control register kept. A character in flight on TXD completes.
- RS=10: command register, read/write.
  - [7:6] parity mode: 00 odd, 01 even, 10 mark, 11 space.
  - [5] parity enable.
  - [3:2] TIC: 01 = TX interrupt enabled; 00 = RTSB high; any other value = RTSB low.
  - [1] RX IRQ disable.
  - [0] DTR, which also globally enables IRQs.
- RS=11: control register, read/write.
  - [7] stop bits: 0 = one, 1 = two.
  - [6:5] word length: 00 = 8, 01 = 7, 10 = 6, 11 = 5.
  - [3:0] divisor D; tick period = CLK_DIV*(D+1) clocks.
- Baud generator: counter reloads on tick. A control write restarts the counter at 0.
- TX FSM IDLE -> START -> DATA -> PARITY(opt) -> STOP -> IDLE:
  - Each bit is 16 ticks; LSB first.
  - Leaves IDLE only when the FIFO is not empty and CTSB is sampled low (6551 rule).
  - The pop occurs on entry to START.
- RX FSM IDLE -> START -> DATA -> PARITY(opt) -> STOP:
  - Start is detected on a falling RXD edge.
  - The start bit is re-checked at tick 8; if high, return to IDLE (glitch).
  - Bits are sampled at mid-bit (tick 8); only the first stop bit is checked.
  - Unused upper data bits of short words = 0.
  - Stop low sets frame error; the byte is still stored.
  - Parity mismatch sets parity error.
  - FIFO full at store: drop the new byte and set overrun.
- Error flags are sticky until an RS=00 read or a programmed reset.
- Simultaneous push and pop on a FIFO in one cycle:
  - Both are performed and the level is unchanged.
  - Push to a full FIFO with a same-cycle pop succeeds.
- IRQn low (registered, 1 cycle after the condition) when DTR=1 AND one of:
  - TIC=01 and TX empty;
  - RX IRQ enabled ([1]=0) and RX level >= RX_THRESH;
  - RX IRQ enabled and any error flag set.
- Reset mid-character: TXD goes to 1 the next cycle; the partial RX character is discarded.

Optional Feature:
- Macro ACIA_FIFO_HWFLOW_EN.
- Defined:
  - RTSB is forced high whenever RX level >= DEPTH-2, regardless of TIC.
  - RTSB returns to the TIC value when the level is <= DEPTH-4 (hysteresis).
  - Status bit6 reads the auto-RTS state instead of TX full.
- Undefined: RTSB is purely TIC-driven; status bit6 = TX full.

Test Plan:
- Reset (RESET=1 for 2 cycles) -> TXD=1, RTSB=1, DTRB=1, IRQn=1; status read = 0x10.
- Control 0x10 (D=0, 8N1), CLK_DIV=13, write 0x55 with CTSB=0 -> TXD shows start plus 0x55 LSB first plus stop; each bit = 208 clocks; status bit4 returns to 1 after stop.
- Loop TXD->RXD, write 17 bytes 0x00..0x10 with DEPTH=16 -> byte 0x10 dropped; 16 bytes read back in order; status bit3 clears after the 16th read.
- Command 0x09 (DTR, TIC=10, RX IRQ enabled), RX_THRESH=8, receive 8 bytes -> IRQn low 1 cycle after the 8th store; one RS=00 read -> IRQn high.
- Command 0x21, control 0x30 (7 data bits, odd parity), inject 0x41 with even-parity bit -> status bit0=1, data reads 0x41; the next status read shows bit0=0.
- Fill the RX FIFO, inject one more byte -> overrun bit2=1 and FIFO contents unchanged; with ACIA_FIFO_HWFLOW_EN, RTSB goes high at level 14 and returns low after draining to 12.

Source files
------------

// File: rtl/acia_fifo.sv
// rtl/acia_fifo.sv - 6551-compatible ACIA with TX/RX FIFOs, internal baud generator and level IRQ.
// Optional build macro ACIA_FIFO_HWFLOW_EN: automatic RTS deassertion when the RX FIFO nears full.

module acia_fifo_buf #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          flush_i,
    input  logic          push_i,
    input  logic [7:0]    din_i,
    input  logic          pop_i,
    output logic [7:0]    head_o,
    output logic [AW:0]   count_o
);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q;
    logic          do_pop, do_push;

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push alongside it.
    assign do_pop  = pop_i && (cnt_q != '0);
    assign do_push = push_i && ((cnt_q != FULL_CNT) || do_pop);
    assign head_o  = mem_q[rd_q];
    assign count_o = cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
            else if (do_pop && !do_push) cnt_q <= cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i && !rst_i) mem_q[wr_q] <= din_i;
    end
endmodule

module acia_fifo #(
    parameter int DEPTH     = 16,
    parameter int CLK_DIV   = 13,
    parameter int RX_THRESH = 8
) (
    input  logic       PHI2,
    input  logic       RESET,
    input  logic       CS,
    input  logic       RWN,
    input  logic [1:0] RS,
    input  logic [7:0] DATAIN,
    output logic [7:0] DATAOUT,
    input  logic       RXD,
    output logic       TXD,
    output logic       RTSB,
    input  logic       CTSB,
    output logic       DTRB,
    output logic       IRQn
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(CLK_DIV * 16);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] THR_CNT  = CW'(RX_THRESH);

    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PAR, ST_STOP} ser_state_e;

    logic          cs_q, acc, wr_acc, rd_acc, prog_rst, tx_push, rx_pop;
    logic [7:0]    cmd_q, ctrl_q, dout_q, last_q, status;
    logic          ovr_q, fe_q, pe_q, irqn_q, irq_d, rtsb_q, stat6;
    logic [BW-1:0] baud_q, baud_lim;
    logic          tick;
    logic [2:0]    rxd_s_q;
    logic [1:0]    ctsb_s_q;
    logic [2:0]    nbits_m1;

    logic [7:0]    tx_head, rx_head;
    logic [CW-1:0] tx_cnt, rx_cnt;
    logic          tx_pop, rx_full;

    ser_state_e    tx_st_q, rx_st_q;
    logic [3:0]    tx_tk_q, rx_tk_q;
    logic [2:0]    tx_bit_q, rx_bit_q;
    logic [7:0]    tx_sh_q, rx_sh_q, rx_byte_q;
    logic          tx_par_q, tx_stop2_q, txd_q;
    logic          rx_push_q, rx_fe_q, rx_pe_q, rx_pe_pend_q;

    function automatic logic calc_par(input logic [7:0] d, input logic [1:0] mode, input logic [1:0] wl);
        logic [7:0] dm;
        dm = d & (8'hFF >> wl);
        case (mode)
            2'b00:   calc_par = ~^dm;
            2'b01:   calc_par = ^dm;
            2'b10:   calc_par = 1'b1;
            default: calc_par = 1'b0;
        endcase
    endfunction

    // One access per CS low period: act only on the cycle CS is first seen low.
    assign acc      = cs_q && !CS;
    assign wr_acc   = acc && !RWN;
    assign rd_acc   = acc && RWN;
    assign tx_push  = wr_acc && (RS == 2'd0);
    assign prog_rst = wr_acc && (RS == 2'd1);
    assign rx_pop   = rd_acc && (RS == 2'd0);
    assign rx_full  = (rx_cnt == FULL_CNT);
    assign nbits_m1 = 3'd7 - {1'b0, ctrl_q[6:5]};

    acia_fifo_buf #(.DEPTH(DEPTH)) u_tx_fifo (
        .clk_i(PHI2), .rst_i(RESET), .flush_i(prog_rst),
        .push_i(tx_push), .din_i(DATAIN), .pop_i(tx_pop),
        .head_o(tx_head), .count_o(tx_cnt)
    );

    acia_fifo_buf #(.DEPTH(DEPTH)) u_rx_fifo (
        .clk_i(PHI2), .rst_i(RESET), .flush_i(prog_rst),
        .push_i(rx_push_q), .din_i(rx_byte_q), .pop_i(rx_pop),
        .head_o(rx_head), .count_o(rx_cnt)
    );

    assign baud_lim = BW'(CLK_DIV * (int'(ctrl_q[3:0]) + 1) - 1);
    assign tick     = (baud_q == baud_lim);

    always_ff @(posedge PHI2) begin
        if (RESET) begin
            cs_q     <= 1'b1;
            rxd_s_q  <= 3'b111;
            ctsb_s_q <= 2'b11;
            baud_q   <= '0;
        end else begin
            cs_q     <= CS;
            rxd_s_q  <= {rxd_s_q[1:0], RXD};
            ctsb_s_q <= {ctsb_s_q[0], CTSB};
            if ((wr_acc && RS == 2'd3) || tick) baud_q <= '0;
            else                                baud_q <= baud_q + 1'b1;
        end
    end

    // Transmitter only moves on baud ticks, so every bit is exactly 16 tick periods.
    assign tx_pop = (tx_st_q == ST_IDLE) && tick && (tx_cnt != '0) && !ctsb_s_q[1];

    always_ff @(posedge PHI2) begin
        if (RESET) begin
            tx_st_q    <= ST_IDLE;
            tx_tk_q    <= '0;
            tx_bit_q   <= '0;
            tx_sh_q    <= '0;
            tx_par_q   <= 1'b0;
            tx_stop2_q <= 1'b0;
            txd_q      <= 1'b1;
        end else if (tick) begin
            tx_tk_q <= tx_tk_q + 4'd1;
            case (tx_st_q)
                ST_IDLE: begin
                    tx_tk_q <= '0;
                    if (tx_pop) begin
                        tx_st_q  <= ST_START;
                        tx_sh_q  <= tx_head;
                        tx_par_q <= calc_par(tx_head, cmd_q[7:6], ctrl_q[6:5]);
                        tx_bit_q <= '0;
                        txd_q    <= 1'b0;
                    end
                end
                ST_START: if (tx_tk_q == 4'd15) begin
                    tx_st_q <= ST_DATA;
                    txd_q   <= tx_sh_q[0];
                    tx_sh_q <= {1'b0, tx_sh_q[7:1]};
                end
                ST_DATA: if (tx_tk_q == 4'd15) begin
                    if (tx_bit_q == nbits_m1) begin
                        tx_stop2_q <= ctrl_q[7];
                        tx_st_q    <= cmd_q[5] ? ST_PAR : ST_STOP;
                        txd_q      <= cmd_q[5] ? tx_par_q : 1'b1;
                    end else begin
                        tx_bit_q <= tx_bit_q + 3'd1;
                        txd_q    <= tx_sh_q[0];
                        tx_sh_q  <= {1'b0, tx_sh_q[7:1]};
                    end
                end
                ST_PAR: if (tx_tk_q == 4'd15) begin
                    tx_st_q <= ST_STOP;
                    txd_q   <= 1'b1;
                end
                ST_STOP: if (tx_tk_q == 4'd15) begin
                    if (tx_stop2_q) tx_stop2_q <= 1'b0;
                    else            tx_st_q    <= ST_IDLE;
                end
                default: tx_st_q <= ST_IDLE;
            endcase
        end
    end

    // Receiver: sample mid-bit; the state after the start check counts 16 ticks per bit.
    always_ff @(posedge PHI2) begin
        if (RESET) begin
            rx_st_q      <= ST_IDLE;
            rx_tk_q      <= '0;
            rx_bit_q     <= '0;
            rx_sh_q      <= '0;
            rx_byte_q    <= '0;
            rx_push_q    <= 1'b0;
            rx_fe_q      <= 1'b0;
            rx_pe_q      <= 1'b0;
            rx_pe_pend_q <= 1'b0;
        end else begin
            rx_push_q <= 1'b0;
            if (rx_st_q == ST_IDLE) begin
                if (rxd_s_q[2] && !rxd_s_q[1]) begin
                    rx_st_q      <= ST_START;
                    rx_tk_q      <= '0;
                    rx_bit_q     <= '0;
                    rx_sh_q      <= '0;
                    rx_pe_pend_q <= 1'b0;
                end
            end else if (tick) begin
                rx_tk_q <= rx_tk_q + 4'd1;
                case (rx_st_q)
                    ST_START: if (rx_tk_q == 4'd7) begin
                        rx_tk_q <= '0;
                        rx_st_q <= rxd_s_q[1] ? ST_IDLE : ST_DATA;
                    end
                    ST_DATA: if (rx_tk_q == 4'd15) begin
                        rx_sh_q[rx_bit_q] <= rxd_s_q[1];
                        if (rx_bit_q == nbits_m1) rx_st_q  <= cmd_q[5] ? ST_PAR : ST_STOP;
                        else                      rx_bit_q <= rx_bit_q + 3'd1;
                    end
                    ST_PAR: if (rx_tk_q == 4'd15) begin
                        rx_pe_pend_q <= (rxd_s_q[1] != calc_par(rx_sh_q, cmd_q[7:6], ctrl_q[6:5]));
                        rx_st_q      <= ST_STOP;
                    end
                    ST_STOP: if (rx_tk_q == 4'd15) begin
                        rx_push_q <= 1'b1;
                        rx_byte_q <= rx_sh_q;
                        rx_fe_q   <= !rxd_s_q[1];
                        rx_pe_q   <= cmd_q[5] && rx_pe_pend_q;
                        rx_st_q   <= ST_IDLE;
                    end
                    default: rx_st_q <= ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge PHI2) begin
        if (RESET || prog_rst) begin
            ovr_q <= 1'b0;
            fe_q  <= 1'b0;
            pe_q  <= 1'b0;
        end else begin
            if (rx_pop) begin
                ovr_q <= 1'b0;
                fe_q  <= 1'b0;
                pe_q  <= 1'b0;
            end
            if (rx_push_q) begin
                if (rx_fe_q) fe_q <= 1'b1;
                if (rx_pe_q) pe_q <= 1'b1;
                if (rx_full && !rx_pop) ovr_q <= 1'b1;
            end
        end
    end

`ifdef ACIA_FIFO_HWFLOW_EN
    localparam logic [CW-1:0] HI_WATER = CW'(DEPTH - 2);
    localparam logic [CW-1:0] LO_WATER = CW'(DEPTH - 4);
    logic auto_rts_q;

    always_ff @(posedge PHI2) begin
        if (RESET)                    auto_rts_q <= 1'b0;
        else if (rx_cnt >= HI_WATER)  auto_rts_q <= 1'b1;
        else if (rx_cnt <= LO_WATER)  auto_rts_q <= 1'b0;
    end
    assign stat6 = auto_rts_q;
`else
    assign stat6 = (tx_cnt == FULL_CNT);
`endif

    assign irq_d = cmd_q[0] && (((cmd_q[3:2] == 2'b01) && (tx_cnt == '0)) ||
                                (!cmd_q[1] && ((rx_cnt >= THR_CNT) || ovr_q || fe_q || pe_q)));
    assign status = {irq_d, stat6, (rx_cnt >= THR_CNT), (tx_cnt == '0), (rx_cnt != '0), ovr_q, fe_q, pe_q};

    always_ff @(posedge PHI2) begin
        if (RESET) begin
            cmd_q  <= '0;
            ctrl_q <= '0;
            dout_q <= '0;
            last_q <= '0;
            irqn_q <= 1'b1;
            rtsb_q <= 1'b1;
        end else begin
            irqn_q <= !irq_d;
`ifdef ACIA_FIFO_HWFLOW_EN
            rtsb_q <= (cmd_q[3:2] == 2'b00) || auto_rts_q;
`else
            rtsb_q <= (cmd_q[3:2] == 2'b00);
`endif
            if (prog_rst) cmd_q <= {cmd_q[7:5], 5'b0};
            if (wr_acc && RS == 2'd2) cmd_q  <= DATAIN;
            if (wr_acc && RS == 2'd3) ctrl_q <= DATAIN;
            if (rd_acc) begin
                case (RS)
                    2'd0: begin
                        if (rx_cnt != '0) begin
                            dout_q <= rx_head;
                            last_q <= rx_head;
                        end else begin
                            dout_q <= last_q;
                        end
                    end
                    2'd1:    dout_q <= status;
                    2'd2:    dout_q <= cmd_q;
                    default: dout_q <= ctrl_q;
                endcase
            end
        end
    end

    assign DATAOUT = dout_q;
    assign TXD     = txd_q;
    assign RTSB    = rtsb_q;
    assign DTRB    = ~cmd_q[0];
    assign IRQn    = irqn_q;
endmodule
